// File: rtl/lcd_spi_tx_if.sv
// Host-side handshake bundle for the LCD SPI transmitter: byte request in, status out.
interface lcd_spi_tx_if;
  logic       load;
  logic [7:0] data_in;
  logic       is_cmd;
  logic       busy;
  logic       ready;

  modport master (output load, data_in, is_cmd, input busy, ready);
  modport slave  (input load, data_in, is_cmd, output busy, ready);
endinterface

// File: rtl/lcd_spi_tx.sv
// Write-only SPI mode-0 byte transmitter for a TFT panel, including the panel
// hardware-reset and power-up wait sequence that gates the ready flag.
module lcd_spi_tx #(
  parameter int CLK_DIV           = 4,
  parameter int RESET_LOW_CYCLES  = 1000000,
  parameter int RESET_WAIT_CYCLES = 12000000
) (
  input  logic         CLK_100MHz,
  input  logic         RST,
  lcd_spi_tx_if.slave  host,
  output logic         TFT_CS,
  output logic         TFT_RESET,
  output logic         TFT_SDI,
  output logic         TFT_SCK,
  output logic         TFT_DC
);

  localparam int MAX_CYCLES = (RESET_LOW_CYCLES > RESET_WAIT_CYCLES) ?
                              RESET_LOW_CYCLES : RESET_WAIT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RESET_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESET_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       DIV_LAST  = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_IDLE,
    ST_SHIFT,
    ST_TRAIL
  } state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [7:0]       r_div, w_div;
  logic             r_half, w_half;
  logic [2:0]       r_bit, w_bit;
  logic [6:0]       r_shift, w_shift;
  logic             r_cs, w_cs;
  logic             r_tftReset, w_tftReset;
  logic             r_sck, w_sck;
  logic             r_sdi, w_sdi;
  logic             r_dc, w_dc;
  logic             r_busy, w_busy;
  logic             r_ready, w_ready;

  // Every output is a register, so the shift register only keeps bits 6..0;
  // bit 7 goes straight to SDI on the accept edge.
  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      r_state    <= ST_RST_LOW;
      r_cnt      <= '0;
      r_div      <= '0;
      r_half     <= 1'b0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_cs       <= 1'b1;
      r_tftReset <= 1'b0;
      r_sck      <= 1'b0;
      r_sdi      <= 1'b0;
      r_dc       <= 1'b1;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_div      <= w_div;
      r_half     <= w_half;
      r_bit      <= w_bit;
      r_shift    <= w_shift;
      r_cs       <= w_cs;
      r_tftReset <= w_tftReset;
      r_sck      <= w_sck;
      r_sdi      <= w_sdi;
      r_dc       <= w_dc;
      r_busy     <= w_busy;
      r_ready    <= w_ready;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_div      = r_div;
    w_half     = r_half;
    w_bit      = r_bit;
    w_shift    = r_shift;
    w_cs       = r_cs;
    w_tftReset = r_tftReset;
    w_sck      = r_sck;
    w_sdi      = r_sdi;
    w_dc       = r_dc;
    w_busy     = r_busy;
    w_ready    = r_ready;

    case (r_state)
      ST_RST_LOW: begin
        w_tftReset = 1'b0;
        if (r_cnt == LOW_LAST) begin
          w_cnt      = '0;
          w_tftReset = 1'b1;
          w_state    = ST_RST_WAIT;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end

      ST_RST_WAIT: begin
        if (r_cnt == WAIT_LAST) begin
          w_cnt   = '0;
          w_ready = 1'b1;
          w_state = ST_IDLE;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end

      ST_IDLE: begin
        w_cs   = 1'b1;
        w_sck  = 1'b0;
        w_busy = 1'b0;
        if (host.load) begin
          w_shift = host.data_in[6:0];
          w_sdi   = host.data_in[7];
          w_dc    = ~host.is_cmd;
          w_cs    = 1'b0;
          w_busy  = 1'b1;
          w_div   = '0;
          w_half  = 1'b0;
          w_bit   = '0;
          w_state = ST_SHIFT;
        end
      end

      // Low half then high half per bit; SDI advances only on the falling
      // SCK edge between bits, so bit 0 is held through TRAIL and beyond.
      ST_SHIFT: begin
        if (r_div == DIV_LAST) begin
          w_div = '0;
          if (!r_half) begin
            w_half = 1'b1;
            w_sck  = 1'b1;
          end else begin
            w_half = 1'b0;
            w_sck  = 1'b0;
            if (r_bit == 3'd7) begin
              w_state = ST_TRAIL;
            end else begin
              w_bit   = r_bit + 3'd1;
              w_sdi   = r_shift[6];
              w_shift = {r_shift[5:0], 1'b0};
            end
          end
        end else begin
          w_div = r_div + 8'd1;
        end
      end

      ST_TRAIL: begin
        if (r_div == DIV_LAST) begin
          w_div   = '0;
          w_cs    = 1'b1;
          w_busy  = 1'b0;
          w_state = ST_IDLE;
        end else begin
          w_div = r_div + 8'd1;
        end
      end

      default: begin
        w_state = ST_RST_LOW;
      end
    endcase
  end

  assign TFT_CS     = r_cs;
  assign TFT_RESET  = r_tftReset;
  assign TFT_SDI    = r_sdi;
  assign TFT_SCK    = r_sck;
  assign TFT_DC     = r_dc;
  assign host.busy  = r_busy;
  assign host.ready = r_ready;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Self-checking bench for lcd_spi_tx: init timing, table vectors, random bytes
// against a bit-queue model, back-to-back transfers and resets mid-byte.
module tb_lcd_spi_tx;

  localparam int CLK_DIV  = 2;
  localparam int LOW_CYC  = 10;
  localparam int WAIT_CYC = 20;
  localparam int BUSY_LEN = 17 * CLK_DIV;

  logic CLK_100MHz = 1'b0;
  logic RST        = 1'b1;
  logic tftCs, tftReset, tftSdi, tftSck, tftDc;

  lcd_spi_tx_if hostIf ();

  lcd_spi_tx #(
    .CLK_DIV          (CLK_DIV),
    .RESET_LOW_CYCLES (LOW_CYC),
    .RESET_WAIT_CYCLES(WAIT_CYC)
  ) dut (
    .CLK_100MHz(CLK_100MHz),
    .RST       (RST),
    .host      (hostIf),
    .TFT_CS    (tftCs),
    .TFT_RESET (tftReset),
    .TFT_SDI   (tftSdi),
    .TFT_SCK   (tftSck),
    .TFT_DC    (tftDc)
  );

  always #5 CLK_100MHz = ~CLK_100MHz;

  typedef struct {
    logic [7:0] data;
    logic       isCmd;
    logic [7:0] expBits;
    logic       expDc;
    int         expBusy;
  } vec_t;

  vec_t vecs [4];

  int nCompared = 0;
  int nMismatch = 0;

  logic [7:0] capBits;
  int         capRises, capBusy, capCsErr, capDcErr;
  logic       capDc, capCsEnd;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [7:0] d, input logic cmd);
    hostIf.load    = ld;
    hostIf.data_in = d;
    hostIf.is_cmd  = cmd;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Cs"},    32'(tftCs),        32'd1);
    checkOutput({tag, "Reset"}, 32'(tftReset),     32'd0);
    checkOutput({tag, "Sck"},   32'(tftSck),       32'd0);
    checkOutput({tag, "Sdi"},   32'(tftSdi),       32'd0);
    checkOutput({tag, "Dc"},    32'(tftDc),        32'd1);
    checkOutput({tag, "Busy"},  32'(hostIf.busy),  32'd0);
    checkOutput({tag, "Ready"}, 32'(hostIf.ready), 32'd0);
  endtask

  // Asserts RST now, holds it for 'hold' edges, releases it and measures the
  // TFT_RESET low time and the wait until ready, sampling on falling edges.
  task automatic resetAndInit(input string tag, input int hold, input bit loadInWait);
    int lowCnt  = 0;
    int waitCnt = 0;
    int bad     = 0;
    int guard   = 0;
    RST = 1'b1;
    @(posedge CLK_100MHz); #1;
    checkResetValues({tag, "First"});
    repeat (hold - 1) begin
      @(posedge CLK_100MHz); #1;
    end
    if (hold > 1) checkResetValues({tag, "Held"});
    RST = 1'b0;
    @(negedge CLK_100MHz);
    while (tftReset == 1'b0 && guard < 500) begin
      lowCnt++;
      guard++;
      if (hostIf.busy || !tftCs || tftSck || hostIf.ready) bad++;
      @(negedge CLK_100MHz);
    end
    while (hostIf.ready == 1'b0 && guard < 500) begin
      waitCnt++;
      guard++;
      if (hostIf.busy || !tftCs || tftSck || !tftReset) bad++;
      if (loadInWait && waitCnt == 3)  hostIf.load = 1'b1;
      if (loadInWait && waitCnt == 15) hostIf.load = 1'b0;
      @(negedge CLK_100MHz);
    end
    checkOutput({tag, "LowCycles"},  32'(lowCnt),       32'(LOW_CYC));
    checkOutput({tag, "WaitCycles"}, 32'(waitCnt),      32'(WAIT_CYC));
    checkOutput({tag, "InitQuiet"},  32'(bad),          32'd0);
    checkOutput({tag, "ReadyUp"},    32'(hostIf.ready), 32'd1);
  endtask

  task automatic launchByte(input logic [7:0] d, input logic cmd);
    int guard = 0;
    applyStimulus(1'b1, d, cmd);
    @(negedge CLK_100MHz);
    while (!hostIf.busy && guard < 10) begin
      guard++;
      @(negedge CLK_100MHz);
    end
  endtask

  // Entered on the first sample showing busy; collects SDI at each SCK rise.
  task automatic captureByte();
    logic prevSck = 1'b0;
    capBits  = '0;
    capRises = 0;
    capBusy  = 0;
    capCsErr = 0;
    capDcErr = 0;
    capDc    = tftDc;
    while (hostIf.busy && capBusy < 400) begin
      capBusy++;
      if (tftCs) capCsErr++;
      if (tftDc !== capDc) capDcErr++;
      if (tftSck && !prevSck) begin
        capBits = {capBits[6:0], tftSdi};
        capRises++;
      end
      prevSck = tftSck;
      @(negedge CLK_100MHz);
    end
    capCsEnd = tftCs;
  endtask

  task automatic checkByte(input string tag, input logic [7:0] expBits,
                           input logic expDc, input int expBusy);
    checkOutput({tag, "Bits"},  32'(capBits),  32'(expBits));
    checkOutput({tag, "Rises"}, 32'(capRises), 32'd8);
    checkOutput({tag, "Busy"},  32'(capBusy),  32'(expBusy));
    checkOutput({tag, "Dc"},    32'(capDc),    32'(expDc));
    checkOutput({tag, "DcHeld"},32'(capDcErr), 32'd0);
    checkOutput({tag, "CsLow"}, 32'(capCsErr), 32'd0);
    checkOutput({tag, "CsEnd"}, 32'(capCsEnd), 32'd1);
  endtask

  task automatic checkQuiet(input string tag, input int cycles);
    int bad = 0;
    repeat (cycles) begin
      if (hostIf.busy || !tftCs || tftSck) bad++;
      @(negedge CLK_100MHz);
    end
    checkOutput(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rd, expBits;
    logic       rc;
    int         gap, sckErr, rises, guard;
    logic       prev;
    bit         q [$];

    vecs[0] = '{data: 8'hA5, isCmd: 1'b1, expBits: 8'b1010_0101, expDc: 1'b0, expBusy: 34};
    vecs[1] = '{data: 8'h3C, isCmd: 1'b0, expBits: 8'b0011_1100, expDc: 1'b1, expBusy: 34};
    vecs[2] = '{data: 8'h80, isCmd: 1'b0, expBits: 8'b1000_0000, expDc: 1'b1, expBusy: 34};
    vecs[3] = '{data: 8'h01, isCmd: 1'b1, expBits: 8'b0000_0001, expDc: 1'b0, expBusy: 34};

    applyStimulus(1'b0, 8'h00, 1'b0);
    resetAndInit("por", 4, 1'b0);

    // Single bytes, load dropped once busy is seen and inputs scrambled.
    for (int i = 0; i < 4; i++) begin
      launchByte(vecs[i].data, vecs[i].isCmd);
      applyStimulus(1'b0, ~vecs[i].data, ~vecs[i].isCmd);
      captureByte();
      checkByte($sformatf("vec%0d", i), vecs[i].expBits, vecs[i].expDc, vecs[i].expBusy);
      checkQuiet($sformatf("vec%0dOnce", i), 20);
    end

    for (int n = 0; n < 16; n++) begin
      rd = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      q.delete();
      for (int b = 7; b >= 0; b--) q.push_back(rd[b]);
      expBits = '0;
      foreach (q[k]) expBits = {expBits[6:0], q[k]};
      launchByte(rd, rc);
      applyStimulus(1'b0, 8'($urandom), 1'($urandom));
      captureByte();
      checkByte($sformatf("rnd%0d", n), expBits, ~rc, BUSY_LEN);
      repeat ($urandom_range(0, 3)) @(negedge CLK_100MHz);
    end

    // Continuous load: two back-to-back bytes with a CS-high gap between.
    launchByte(8'hFF, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b1);
    captureByte();
    checkByte("b2bFirst", 8'hFF, 1'b1, BUSY_LEN);
    gap = 0;
    sckErr = 0;
    while (!hostIf.busy && gap < 20) begin
      gap++;
      if (tftSck || !tftCs) sckErr++;
      @(negedge CLK_100MHz);
    end
    checkOutput("b2bGap", 32'(gap >= 1 && gap < 20), 32'd1);
    checkOutput("b2bGapSck", 32'(sckErr), 32'd0);
    applyStimulus(1'b0, 8'h5A, 1'b0);
    captureByte();
    checkByte("b2bSecond", 8'h00, 1'b0, BUSY_LEN);
    checkQuiet("b2bStop", 40);

    // Load pulsed during the power-up wait must never start a byte.
    resetAndInit("waitLoad", 2, 1'b1);
    checkQuiet("waitLoadQuiet", 40);

    // Reset after the third SCK rise aborts the byte and reruns init.
    launchByte(8'hC3, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    rises = 0;
    guard = 0;
    prev  = tftSck;
    while (rises < 3 && guard < 200) begin
      @(negedge CLK_100MHz);
      guard++;
      if (tftSck && !prev) rises++;
      prev = tftSck;
    end
    checkOutput("midRises", 32'(rises), 32'd3);
    resetAndInit("mid", 3, 1'b0);

    launchByte(8'hA5, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    captureByte();
    checkByte("postReset", 8'b1010_0101, 1'b0, BUSY_LEN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/lcd_spi_tx.md
LCD_SPI_TX -- requirements
Module: lcd_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 4; system clocks per SCK half-period (SCK = 100 MHz / (2*CLK_DIV) = 12.5 MHz); legal range 1..255.
REQ-002 Parameter RESET_LOW_CYCLES, default 1000000; clocks TFT_RESET is held low after reset (10 ms).
REQ-003 Parameter RESET_WAIT_CYCLES, default 12000000; clocks from TFT_RESET rising until ready asserts (120 ms).
REQ-004 CLK_100MHz  in  1  the only clock; all logic on its rising edge.
REQ-005 RST  in  1  reset; synchronous to CLK_100MHz, active-high.
REQ-006 load  in  1  level request to send one byte; the host holds it until busy is seen high.
REQ-007 data_in  in  8  byte to transmit; sampled on the accept edge only.
REQ-008 is_cmd  in  1  1 = command byte (DC low), 0 = data byte (DC high); sampled with data_in.
REQ-009 TFT_CS  out  1  panel chip select, active-low.
REQ-010 TFT_RESET  out  1  panel hardware reset, active-low.
REQ-011 TFT_SDI  out  1  serial data, MSB first.
REQ-012 TFT_SCK  out  1  serial clock, SPI mode 0 (idle low, panel samples on rising edge).
REQ-013 TFT_DC  out  1  data/command select.
REQ-014 busy  out  1  a byte transfer is in progress.
REQ-015 ready  out  1  panel init is complete; stays 1 through every later transfer.

Function
REQ-016 State machine: RST_LOW -> RST_WAIT -> IDLE -> SHIFT -> TRAIL -> IDLE; RST forces RST_LOW.
REQ-017 RST_LOW: TFT_RESET=0 for exactly RESET_LOW_CYCLES clocks counted from the first clock after RST deasserts; then TFT_RESET=1 and enter RST_WAIT.
REQ-018 RST_WAIT: count RESET_WAIT_CYCLES clocks; then enter IDLE with ready=1 on the same edge.
REQ-019 load is ignored (not latched) in RST_LOW and RST_WAIT; a load still high on entering IDLE is accepted.
REQ-020 IDLE accept: load=1 on an edge latches data_in and is_cmd into the shift register; the next cycle shows busy=1, TFT_CS=0, TFT_DC=~is_cmd, TFT_SDI=bit7, TFT_SCK=0 (SHIFT).
REQ-021 SHIFT, each bit: SCK low for CLK_DIV clocks, then high for CLK_DIV clocks; SDI changes only on SCK falling, or at transfer start for bit7; bits go 7 down to 0.
REQ-022 After bit0's high half: SCK=0, enter TRAIL; CS stays low for CLK_DIV clocks.
REQ-023 End of TRAIL: TFT_CS=1 and busy=0 on the same edge; return to IDLE; SDI holds bit0, DC holds its value.
REQ-024 busy stays high for exactly 17*CLK_DIV clocks per byte (68 at the default).
REQ-025 load high on the edge that ends TRAIL starts no transfer; a load still high in IDLE on the next edge starts a new one (load is level-sensitive in IDLE only).
REQ-026 load, data_in and is_cmd changes while busy=1 have no effect on the byte in flight.
REQ-027 Counters are wide enough for the maximum parameter values; no wrap-around inside any phase.
REQ-028 TFT_CS is high in every state except SHIFT and TRAIL; TFT_SCK is low in every state except the SHIFT high half.

Reset
REQ-029 On an edge with RST=1, all outputs take these values: TFT_CS=1, TFT_RESET=0, TFT_SCK=0, TFT_SDI=0, TFT_DC=1, busy=0, ready=0.
REQ-030 On that edge, all counters and the shift register clear and the state is RST_LOW.
REQ-031 RST asserted mid-transfer aborts the byte at once (CS high on the next edge) and restarts the full init sequence.
REQ-032 RST held for several clocks keeps the REQ-029 values; the RST_LOW count begins only after release.

Verification (bench parameters CLK_DIV=2, RESET_LOW_CYCLES=10, RESET_WAIT_CYCLES=20 unless stated)
REQ-033 Release RST -> TFT_RESET low for exactly 10 clocks, then high; ready rises 20 clocks later; busy stays 0 throughout.
REQ-034 In IDLE, pulse load with data_in=8'hA5, is_cmd=1 -> DC=0, CS low, 8 SCK rising edges sampling SDI=1,0,1,0,0,1,0,1, busy high 34 clocks, then CS=1.
REQ-035 data_in=8'h3C, is_cmd=0, with load held until busy then dropped -> DC=1, bits 0,0,1,1,1,1,0,0, exactly one byte sent.
REQ-036 load held high continuously (bytes 8'hFF, then 8'h00) -> back-to-back transfers; CS high for at least 1 clock between them, no SCK pulse while CS is high.
REQ-037 load=1 during RST_WAIT, dropped before ready -> no transfer ever starts; CS stays 1.
REQ-038 Assert RST after the 3rd SCK rising edge of a byte -> next edge shows CS=1, SCK=0, busy=0, ready=0, TFT_RESET=0; the init sequence repeats as in REQ-033.
